// File: rtl/mat_mul_arbiter.sv
// mat_mul_arbiter: round-robin front end that shares one N x N matrix multiplier
// between two requesters. A tag FIFO tracks issue order; each result is held until accepted.
module mat_mul_arbiter #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [N*N*W_IN-1:0]    req0_m1,
    input  logic [N*N*W_IN-1:0]    req0_m2,
    input  logic [N*N*W_IN-1:0]    req1_m1,
    input  logic [N*N*W_IN-1:0]    req1_m2,
    output logic                   mm_cen,
    output logic                   mm_valid_in,
    output logic [N*N*W_IN-1:0]    mm_matrix_1,
    output logic [N*N*W_IN-1:0]    mm_matrix_2,
    input  logic                   mm_valid_out,
    input  logic [N*N*W_OUT-1:0]   mm_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_id,
    output logic [N*N*W_OUT-1:0]   result,
    output logic                   err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

    logic                   last_grant_r;
    logic [DEPTH-1:0]       tag_mem_r;
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [CW-1:0]          inflight_r;
    logic                   res_valid_r;
    logic                   res_id_r;
    logic [N*N*W_OUT-1:0]   result_r;
    logic                   err_r;

    logic                   mm_cen_s;
    logic                   can_grant_s;
    logic [1:0]             grant_s;
    logic                   grant_id_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   spurious_s;

    // A held, unaccepted result freezes the multiplier and with it both issue and capture.
    assign mm_cen_s    = ~(res_valid_r & ~res_ready);
    assign can_grant_s = ~rst & mm_cen_s & (inflight_r < DEPTH_C);

    // Round-robin pick: on contention the requester other than the last winner goes.
    always_comb begin
        grant_s    = 2'b00;
        grant_id_s = 1'b0;
        if (can_grant_s) begin
            case (req_valid)
                2'b01: begin
                    grant_s    = 2'b01;
                    grant_id_s = 1'b0;
                end
                2'b10: begin
                    grant_s    = 2'b10;
                    grant_id_s = 1'b1;
                end
                2'b11: begin
                    if (last_grant_r) begin
                        grant_s    = 2'b01;
                        grant_id_s = 1'b0;
                    end else begin
                        grant_s    = 2'b10;
                        grant_id_s = 1'b1;
                    end
                end
                default: begin
                    grant_s    = 2'b00;
                    grant_id_s = 1'b0;
                end
            endcase
        end else begin
            grant_s    = 2'b00;
            grant_id_s = 1'b0;
        end
    end

    assign push_s     = |grant_s;
    assign pop_s      = mm_valid_out & mm_cen_s & (inflight_r != {CW{1'b0}});
    assign spurious_s = mm_valid_out & mm_cen_s & (inflight_r == {CW{1'b0}});

    // Last-grant pointer starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (push_s) begin
            last_grant_r <= grant_id_s;
        end
    end

    // Tag FIFO; its occupancy doubles as the in-flight count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_mem_r  <= {DEPTH{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            inflight_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_id_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   inflight_r <= inflight_r + CNT_ONE;
                2'b01:   inflight_r <= inflight_r - CNT_ONE;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Result holding register; a new capture takes priority over the accept-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_id_r    <= 1'b0;
            result_r    <= {(N*N*W_OUT){1'b0}};
        end else if (pop_s) begin
            res_valid_r <= 1'b1;
            res_id_r    <= tag_mem_r[rd_ptr_r];
            result_r    <= mm_result;
        end else if (res_valid_r & res_ready) begin
            res_valid_r <= 1'b0;
        end
    end

    // Sticky flag for a multiplier strobe that no issue accounts for.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (spurious_s) begin
            err_r <= 1'b1;
        end
    end

    assign req_ready   = grant_s;
    assign mm_cen      = mm_cen_s;
    assign mm_valid_in = push_s;
    assign mm_matrix_1 = grant_s[1] ? req1_m1 : req0_m1;
    assign mm_matrix_2 = grant_s[1] ? req1_m2 : req0_m2;
    assign res_valid   = res_valid_r;
    assign res_id      = res_id_r;
    assign result      = result_r;
    assign err         = err_r;

endmodule

// File: tb/tb_mat_mul_arbiter.sv
// Bench for mat_mul_arbiter: latency-3 multiplier stub with a stall input, and a
// scoreboard filled at each request transfer and drained at each result accept.
module tb_mat_mul_arbiter;

    localparam int W_IN  = 8;
    localparam int W_OUT = 32;
    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int OPW   = N*N*W_IN;
    localparam int RESW  = N*N*W_OUT;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [OPW-1:0]  req0_m1, req0_m2, req1_m1, req1_m2;
    logic            mm_cen, mm_valid_in;
    logic [OPW-1:0]  mm_matrix_1, mm_matrix_2;
    logic            mm_valid_out;
    logic [RESW-1:0] mm_result;
    logic            res_valid, res_ready, res_id, err;
    logic [RESW-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic            id;
        logic [RESW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mat_mul_arbiter #(.W_IN(W_IN), .W_OUT(W_OUT), .N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_m1(req0_m1), .req0_m2(req0_m2), .req1_m1(req1_m1), .req1_m2(req1_m2),
        .mm_cen(mm_cen), .mm_valid_in(mm_valid_in),
        .mm_matrix_1(mm_matrix_1), .mm_matrix_2(mm_matrix_2),
        .mm_valid_out(mm_valid_out), .mm_result(mm_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .result(result), .err(err)
    );

    function automatic logic [RESW-1:0] stub_fn(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        return {a ^ b, a + b, a, b};
    endfunction

    // Multiplier stub: every cen cycle advances its time; results surface 3 cen cycles after issue.
    logic            stub_rst, stub_stall, spurious;
    logic [RESW-1:0] stub_data [0:15];
    int              stub_rdy  [0:15];
    logic [3:0]      sh, st;
    int              scyc;
    logic            stub_vld;

    assign stub_vld     = (sh != st) && (stub_rdy[sh] <= scyc) && !stub_stall;
    assign mm_valid_out = stub_vld | spurious;
    assign mm_result    = stub_data[sh];

    always @(posedge clk) begin
        if (stub_rst) begin
            sh   <= 4'd0;
            st   <= 4'd0;
            scyc <= 0;
        end else if (mm_cen) begin
            scyc <= scyc + 1;
            if (stub_vld) sh <= sh + 4'd1;
            if (mm_valid_in) begin
                stub_data[st] <= stub_fn(mm_matrix_1, mm_matrix_2);
                stub_rdy[st]  <= scyc + 3;
                st            <= st + 4'd1;
            end
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((req_ready & ~req_valid) !== 2'b00 || req_ready === 2'b11) begin
                errors++;
                $display("FAIL ready_onehot: req_ready=%b req_valid=%b required one-hot subset of valid", req_ready, req_valid);
            end
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: res_id=%0d accepted with no pending issue, required none", res_id);
                end else begin
                    mon_e = sb.pop_front();
                    if (res_id !== mon_e.id || result !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_result: res_id=%0d data_match=%0d, required id=%0d data_match=1",
                                 res_id, (result === mon_e.data), mon_e.id);
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) sb.push_back({1'b0, stub_fn(req0_m1, req0_m2)});
            if (req_valid[1] && req_ready[1]) sb.push_back({1'b1, stub_fn(req1_m1, req1_m2)});
        end
    end

    task automatic rand_ops();
        for (int i = 0; i < OPW/32; i++) begin
            req0_m1[i*32 +: 32] = $urandom();
            req0_m2[i*32 +: 32] = $urandom();
            req1_m1[i*32 +: 32] = $urandom();
            req1_m2[i*32 +: 32] = $urandom();
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rand_ops();
    endtask

    task automatic do_reset();
        rst = 1'b1; stub_rst = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
        stub_stall = 1'b0; spurious = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; stub_rst = 1'b0;
        rand_ops();
    endtask

    task automatic drain(input string name);
        int n = 0;
        next_cycle();
        req_valid = 2'b00; res_ready = 1'b1; stub_stall = 1'b0;
        @(negedge clk);
        while ((sb.size() != 0 || res_valid !== 1'b0) && n < 60) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d res_valid=%b, required 0 pending and res_valid=0", name, sb.size(), res_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stub_rst = 1'b1; req_valid = 2'b11; res_ready = 1'b0;
        spurious = 1'b0; stub_stall = 1'b0;
        rand_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, mm_valid_in, res_valid, res_id, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b vin=%b rv=%b id=%b err=%b, required all 0",
                     req_ready, mm_valid_in, res_valid, res_id, err);
        end
        checks++;
        if (result !== {RESW{1'b0}}) begin
            errors++;
            $display("FAIL reset_result: result nonzero, required 0");
        end
        checks++;
        if (mm_cen !== 1'b1) begin
            errors++;
            $display("FAIL reset_cen: mm_cen=%b required 1", mm_cen);
        end
        do_reset();
    endtask

    task automatic test_single();
        req_valid = 2'b01; res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || mm_valid_in !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: req_ready=%b mm_valid_in=%b, required 01 and 1", req_ready, mm_valid_in);
        end
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            req_valid = 2'b00;
            @(negedge clk);
            checks++;
            if (res_valid !== (c == 4)) begin
                errors++;
                $display("FAIL single_latency: cycle %0d res_valid=%b required %b", c, res_valid, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (res_id !== 1'b0) begin
                    errors++;
                    $display("FAIL single_id: res_id=%b required 0", res_id);
                end
            end
        end
        drain("single");
    endtask

    task automatic test_contention();
        logic [1:0] c_req [8];
        logic [1:0] c_gnt [8];
        c_req = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01};
        c_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            req_valid = c_req[i];
            @(negedge clk);
            checks++;
            if (req_ready !== c_gnt[i]) begin
                errors++;
                $display("FAIL rr_grant: step %0d req_ready=%b required %b", i, req_ready, c_gnt[i]);
            end
        end
        drain("contention");
    endtask

    task automatic test_backpressure();
        do_reset();
        res_ready = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) next_cycle();
            req_valid = 2'b11;
            @(negedge clk);
            checks++;
            if (mm_cen !== (c < 4)) begin
                errors++;
                $display("FAIL bp_cen: cycle %0d mm_cen=%b required %b", c, mm_cen, (c < 4));
            end
            if (c >= 4) begin
                checks++;
                if (req_ready !== 2'b00 || mm_valid_in !== 1'b0 || res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_block: cycle %0d ready=%b vin=%b rv=%b, required 00 0 1", c, req_ready, mm_valid_in, res_valid);
                end
                checks++;
                if (sb.size() == 0 || result !== sb[0].data || res_id !== sb[0].id) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d res_id=%b held result differs from first issue", c, res_id);
                end
            end
        end
        drain("backpressure");
    endtask

    task automatic test_credit();
        logic [1:0] exp_r;
        do_reset();
        stub_stall = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) next_cycle();
            req_valid  = 2'b01;
            stub_stall = (c != 10);
            @(negedge clk);
            exp_r = (c < 8 || c == 11) ? 2'b01 : 2'b00;
            checks++;
            if (req_ready !== exp_r) begin
                errors++;
                $display("FAIL credit_ready: cycle %0d req_ready=%b required %b", c, req_ready, exp_r);
            end
            if (c == 9) begin
                checks++;
                if (dut.inflight_r !== 4'd8) begin
                    errors++;
                    $display("FAIL credit_sat: inflight=%0d required 8", dut.inflight_r);
                end
            end
        end
        drain("credit");
    endtask

    task automatic test_simul();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) next_cycle();
            req_valid = (c < 6) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                checks++;
                if (dut.inflight_r !== 4'd3) begin
                    errors++;
                    $display("FAIL simul_inflight: cycle %0d inflight=%0d required 3", c, dut.inflight_r);
                end
            end
            if (c >= 4) begin
                checks++;
                if (res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_continuous: cycle %0d res_valid=%b required 1", c, res_valid);
                end
            end
        end
        drain("simul");
    endtask

    task automatic test_err_reset();
        do_reset();
        spurious = 1'b1;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: err=%b required 0", err);
        end
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            spurious  = 1'b0;
            req_valid = (c >= 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || (c < 3 && res_valid !== 1'b0)) begin
                errors++;
                $display("FAIL err_sticky: cycle %0d err=%b res_valid=%b, required err=1 and no capture", c, err, res_valid);
            end
        end
        next_cycle();
        req_valid = 2'b00;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, err, req_ready, mm_valid_in} !== 6'b0 || result !== {RESW{1'b0}}) begin
            errors++;
            $display("FAIL midrst_outputs: rv=%b id=%b err=%b ready=%b vin=%b, required all 0 and result 0",
                     res_valid, res_id, err, req_ready, mm_valid_in);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale: err=%b res_valid=%b, required err=1 res_valid=0", err, res_valid);
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_credit();
        test_simul();
        test_err_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_mul_arbiter.md
MAT_MUL_ARBITER -- requirements
Module: mat_mul_arbiter

Interface
REQ-001 Parameter W_IN, default 8, signed operand element width.
REQ-002 Parameter W_OUT, default 32, signed result element width.
REQ-003 Parameter N, default 8, matrix dimension (N x N).
REQ-004 Parameter DEPTH, default 8, maximum in-flight operations; power of two, at least 2.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  2  per-requester request valid; bit r belongs to requester r.
REQ-008 req_ready  out  2  per-requester accept; a request transfers when req_valid[r] and req_ready[r] are both high.
REQ-009 req0_m1, req0_m2  in  N*N*W_IN each  requester 0 operands.
REQ-010 req1_m1, req1_m2  in  N*N*W_IN each  requester 1 operands.
REQ-011 mm_cen  out  1  clock enable to the multiplier; low freezes its pipeline.
REQ-012 mm_valid_in  out  1  issue strobe to the multiplier.
REQ-013 mm_matrix_1, mm_matrix_2  out  N*N*W_IN each  muxed operands to the multiplier.
REQ-014 mm_valid_out  in  1  multiplier result strobe.
REQ-015 mm_result  in  N*N*W_OUT  multiplier result.
REQ-016 res_valid  out  1  result held on the output.
REQ-017 res_ready  in  1  consumer accept.
REQ-018 res_id  out  1  requester that owns the held result.
REQ-019 result  out  N*N*W_OUT  held result.
REQ-020 err  out  1  sticky protocol error.

Function
REQ-021 mm_cen SHALL be the inverse of (res_valid and not res_ready), computed combinationally.
REQ-022 The block SHALL grant at most one requester per cycle, and only when mm_cen is 1 and inflight is less than DEPTH.
REQ-023 Arbitration SHALL be round-robin: a last-grant pointer selects the requester other than the last granted when both request, and a sole requester wins regardless of the pointer.
REQ-024 req_ready[r] SHALL be high only for the granted requester, and SHALL not depend on req_valid of the other requester beyond arbitration.
REQ-025 mm_valid_in SHALL equal (any grant), combinationally, in the same cycle as the transfer; mm_matrix_1 and mm_matrix_2 SHALL carry the granted requester's operands, and requester 0's operands when there is no grant.
REQ-026 On each grant, the granted requester id SHALL be pushed into a DEPTH-entry tag FIFO and inflight SHALL be incremented.
REQ-027 When mm_valid_out is 1 and mm_cen is 1, the block SHALL pop the tag FIFO, register mm_result into result and the popped tag into res_id, set res_valid, and decrement inflight.
REQ-028 A simultaneous grant and pop in one cycle SHALL leave inflight unchanged while performing both FIFO operations.
REQ-029 res_valid SHALL clear after a cycle with res_valid and res_ready both high, unless a new result loads in that same cycle, in which case res_valid stays 1 with the new data.
REQ-030 While res_valid is 1 and res_ready is 0, result and res_id SHALL hold stable, and mm_cen=0 SHALL block both issue and capture.
REQ-031 The output path SHALL add one cycle of latency: a result on mm_valid_out in cycle t SHALL appear on res_valid in cycle t+1.
REQ-032 Results SHALL return in issue order, with each res_id equal to the id pushed for that issue.
REQ-033 mm_valid_out arriving with the tag FIFO empty SHALL set err, SHALL capture no result, and SHALL leave inflight unchanged; err stays set until reset.
REQ-034 The inflight count SHALL saturate at DEPTH, and at DEPTH both bits of req_ready SHALL be 0.

Reset
REQ-035 While rst is high: res_valid=0, res_id=0, result=0, err=0, inflight=0, tag FIFO emptied, last-grant pointer=1 so that requester 0 wins first, and req_ready=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight tags and any held result; a multiplier strobe arriving after reset with the FIFO empty SHALL set err per REQ-033.

Verification
REQ-037 Single request: only req_valid[0] held 1 with a stub multiplier of latency 3 -> req_ready[0]=1 in cycle 0, mm_valid_in=1 in cycle 0, res_valid=1 with res_id=0 in cycle 4, then a result accepted with res_ready=1.
REQ-038 Contention: both requesters held high for 4 cycles after reset -> grants in order 0,1,0,1, and res_id returns 0,1,0,1.
REQ-039 Backpressure: res_ready=0 for 5 cycles while results are pending -> mm_cen=0, result stable, no grants; after release, no result is lost or duplicated.
REQ-040 Credit limit: DEPTH=8 with the multiplier stub stalled from producing output -> exactly 8 grants, then req_ready=00 until the first pop, after which one further grant occurs.
REQ-041 Simultaneous events: a grant coinciding with a pop, and an output accept coinciding with a new capture -> inflight unchanged across the grant+pop cycle, and res_valid continuous with new data across the accept+capture cycle.
REQ-042 Error and reset: a spurious mm_valid_out with an empty FIFO sets err=1, and err stays 1 until rst; rst asserted with 3 operations in flight leaves all outputs at reset values the next cycle.
